ak4619_cal: RTL
===============

Name: ak4619_cal

Overview:
- Calibration stage that wraps the AK4619 codec driver on both sides.
- Applies a per-channel offset and gain to the 4 raw ADC samples coming from the driver, and to the 4 user DAC samples going into it.
- Uses one shared 3-stage add/multiply/saturate pipeline, time-multiplexed over all 8 channels once per sample frame.
- Publishes all 8 results together with a one-cycle valid strobe, so downstream DSP and the driver's DAC inputs only ever see complete frames.

Parameters:
- W, 16: sample width in bits, signed; requires W <= 16.
- GW, 16: gain width in bits, signed Q2.(GW-2).
- GAIN_FRAC, 14: gain fractional bits; unity gain = 2^GAIN_FRAC.

Ports:
- clk  in  1  system clock, 12MHz, same clock as the codec driver.
- rst  in  1  synchronous, active-high reset.
- sample_clk  in  1  frame clock from the driver (lrck), in the clk domain.
- adc_raw0..3  in  W each  raw ADC samples from the driver, signed.
- dac_in0..3  in  W each  user DAC samples, signed.
- cal_out0..3  out  W each  calibrated ADC samples, signed.
- dac_out0..3  out  W each  calibrated DAC samples, signed; drive the driver's sample_in0..3.
- out_valid  out  1  one-cycle pulse when a new frame has been published.
- sat_mask  out  8  per-channel saturation flags of the last frame; bits 0-3 = ADC, 4-7 = DAC.
- busy  out  1  high while a frame is being processed.
- overrun  out  1  sticky; set when a frame edge arrives while busy.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  channel index: 0-3 = ADC ch0-3, 4-7 = DAC ch0-3.
- coef_sel  in  1  0 = offset (uses coef_wdata[W-1:0]), 1 = gain.
- coef_wdata  in  16  coefficient value.

Behaviour:
- Clocking and reset: single clock, clk; synchronous, active-high reset, rst.
- Reset values:
  - all outputs 0, including out_valid, busy, overrun and sat_mask;
  - all offsets 0, all gains 2^GAIN_FRAC (identity);
  - FSM returns to IDLE.
- rst asserted mid-frame: the frame is abandoned and the outputs keep no partial results.
- Frame edge: sclk_q is sample_clk registered on clk. A frame edge is sclk_q=1 and sample_clk=0 (falling edge). Cycle E is the cycle in which the edge is detected.
- FSM states: IDLE, ISSUE, DRAIN, PUBLISH.
  - IDLE, on edge in cycle E: capture adc_raw0..3, dac_in0..3 and a snapshot of all 16 coefficients; go to ISSUE.
  - ISSUE, cycles E+1..E+8: issue channel idx 0..7, one per cycle.
  - DRAIN, cycles E+9..E+11: flush the pipeline.
  - PUBLISH, cycle E+12: copy the internal result registers to the outputs; go to IDLE.
- Output timing: all 8 results and sat_mask change together. out_valid is high for exactly cycle E+13.
- busy is high from E+1 through E+12.
- Pipeline, per channel:
  - Stage 1: s = x + offset, computed at W+1 bits, no overflow.
  - Stage 2: p = s * gain, signed, W+1+GW bits.
  - Stage 3: y = p >>> GAIN_FRAC (arithmetic, floor), then saturate to [-2^(W-1), 2^(W-1)-1]. Set the channel's sat bit if clipped.
- Edge while not IDLE: the edge is ignored and overrun is set. overrun stays set until rst. The current frame completes unaffected.
- Coefficient writes:
  - Accepted in any cycle and take effect in the registers on the next clock.
  - A frame uses only its snapshot, so a write in cycle E or later applies to the next frame.
- No handshake with the driver: the frame period is 128 clks and the latency is 13 clks, so dac_out is stable long before the driver's next falling-edge latch.

Decomposition:
- Package cal_pkg:
  - GAIN_ONE constant;
  - N_CH=8 and N_ADC=4 constants;
  - state_t enum {IDLE, ISSUE, DRAIN, PUBLISH};
  - coef_t struct {offset, gain}.
- Sub-module cal_datapath: the 3-stage add/multiply/shift/saturate pipeline, carrying the channel index and a valid bit alongside the data.
- Top level: edge detect, FSM, coefficient and snapshot registers, result and output registers.

Test Plan:
- Identity: reset, adc_raw0=1234, dac_in3=-500, falling edge on sample_clk -> out_valid pulses 13 cycles after detection; cal_out0=1234, dac_out3=-500, sat_mask=0.
- Gain and offset: addr 1 offset=100, gain=0x2000 (0.5), adc_raw1=1000 -> cal_out1=550. Same coefficients with adc_raw1=-103 -> cal_out1=-2 (floor of -1.5).
- Saturation: addr 4 gain=0x7FFF, dac_in0=20000 -> dac_out0=32767, sat_mask[4]=1. addr 2 offset=-1, adc_raw2=-32768 -> cal_out2=-32768, sat_mask[2]=1.
- Overrun: second falling edge forced at E+5 -> ignored; overrun=1 and sticky; outputs at E+13 match the first frame only.
- Write/snapshot race: coefficient write to addr 0 (gain=0x2000) in cycle E with adc_raw0=400 -> this frame cal_out0=400, next frame cal_out0=200.
- Reset mid-frame: rst at E+6 -> no out_valid; all outputs 0 and coefficients back to identity. The next edge gives identity results.

Source files
------------

// File: rtl/ak4619_cal_pkg.sv
// Shared types and constants for the AK4619 calibration stage.
// Coefficients are held at 16 bits; the datapath slices W/GW bits out of them.
package ak4619_cal_pkg;

  localparam int N_CH          = 8;
  localparam int N_ADC         = 4;
  localparam int CW            = 16;
  localparam int GAIN_FRAC_DEF = 14;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PUBLISH} state_t;

  typedef struct packed {
    logic signed [CW-1:0] offset;
    logic signed [CW-1:0] gain;
  } coef_t;

  function automatic logic signed [CW-1:0] unity(input int frac);
    return CW'(1 << frac);
  endfunction

  localparam logic signed [CW-1:0] GAIN_ONE = unity(GAIN_FRAC_DEF);

endpackage

// File: rtl/ak4619_cal_if.sv
// Sample, result and coefficient-write signals between the codec side and the calibration stage.
// master drives samples/coefficients, slave (the calibration block) drives results.
interface ak4619_cal_if #(
  parameter int W = 16
);
  logic                sample_clk;
  logic signed [W-1:0] adc_raw0, adc_raw1, adc_raw2, adc_raw3;
  logic signed [W-1:0] dac_in0, dac_in1, dac_in2, dac_in3;
  logic signed [W-1:0] cal_out0, cal_out1, cal_out2, cal_out3;
  logic signed [W-1:0] dac_out0, dac_out1, dac_out2, dac_out3;
  logic                out_valid;
  logic [7:0]          sat_mask;
  logic                busy;
  logic                overrun;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic                coef_sel;
  logic [15:0]         coef_wdata;

  modport master (
    output sample_clk, adc_raw0, adc_raw1, adc_raw2, adc_raw3,
           dac_in0, dac_in1, dac_in2, dac_in3,
           coef_we, coef_addr, coef_sel, coef_wdata,
    input  cal_out0, cal_out1, cal_out2, cal_out3,
           dac_out0, dac_out1, dac_out2, dac_out3,
           out_valid, sat_mask, busy, overrun
  );

  modport slave (
    input  sample_clk, adc_raw0, adc_raw1, adc_raw2, adc_raw3,
           dac_in0, dac_in1, dac_in2, dac_in3,
           coef_we, coef_addr, coef_sel, coef_wdata,
    output cal_out0, cal_out1, cal_out2, cal_out3,
           dac_out0, dac_out1, dac_out2, dac_out3,
           out_valid, sat_mask, busy, overrun
  );

endinterface

// File: rtl/ak4619_cal_datapath.sv
// Shared offset/gain/saturate pipeline, one channel per cycle, 3 cycles latency.
// No backpressure: every issued channel emerges three cycles later with its index.
module ak4619_cal_datapath
  import ak4619_cal_pkg::*;
#(
  parameter int W         = 16,
  parameter int GW        = 16,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_vld,
  input  logic [2:0]          issue_idx,
  input  logic signed [W-1:0] x,
  input  coef_t               coef,
  output logic                res_vld,
  output logic [2:0]          res_idx,
  output logic signed [W-1:0] res_dat,
  output logic                res_sat
);

  localparam int SW = W + 1;
  localparam int PW = W + 1 + GW;
  localparam logic signed [PW-1:0] YMAX = PW'((2 ** (W - 1)) - 1);
  localparam logic signed [PW-1:0] YMIN = ~YMAX;

  logic                 s1_vld, s2_vld;
  logic [2:0]           s1_idx, s2_idx;
  logic signed [SW-1:0] s1_sum;
  logic signed [GW-1:0] s1_gain;
  logic signed [PW-1:0] s2_prod;
  logic signed [W-1:0]  off;
  logic signed [PW-1:0] shr;

  assign off = coef.offset[W-1:0];
  // Arithmetic shift of a signed product rounds toward minus infinity.
  assign shr = s2_prod >>> GAIN_FRAC;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      res_vld <= 1'b0;
      s1_idx  <= '0;
      s2_idx  <= '0;
      res_idx <= '0;
      s1_sum  <= '0;
      s1_gain <= '0;
      s2_prod <= '0;
      res_dat <= '0;
      res_sat <= 1'b0;
    end else begin
      s1_vld  <= issue_vld;
      s1_idx  <= issue_idx;
      s1_sum  <= $signed({x[W-1], x}) + $signed({off[W-1], off});
      s1_gain <= coef.gain[GW-1:0];

      s2_vld  <= s1_vld;
      s2_idx  <= s1_idx;
      s2_prod <= $signed({{(PW-SW){s1_sum[SW-1]}}, s1_sum})
               * $signed({{(PW-GW){s1_gain[GW-1]}}, s1_gain});

      res_vld <= s2_vld;
      res_idx <= s2_idx;
      if (shr > YMAX) begin
        res_dat <= YMAX[W-1:0];
        res_sat <= 1'b1;
      end else if (shr < YMIN) begin
        res_dat <= YMIN[W-1:0];
        res_sat <= 1'b1;
      end else begin
        res_dat <= shr[W-1:0];
        res_sat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ak4619_cal.sv
// Per-channel offset/gain calibration of 4 ADC + 4 DAC samples, frame published 13 clks after the lrck fall.
// No handshake: edges arriving mid-frame are dropped and flagged in sticky overrun.
module ak4619_cal
  import ak4619_cal_pkg::*;
#(
  parameter int W         = 16,
  parameter int GW        = 16,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
  input logic         clk,
  input logic         rst,
  ak4619_cal_if.slave bus
);

  localparam coef_t COEF_RST = '{offset: '0, gain: unity(GAIN_FRAC)};

  coef_t               coefs [N_CH];
  coef_t               snap  [N_CH];
  logic signed [W-1:0] xs    [N_CH];
  logic signed [W-1:0] res   [N_CH];
  logic [N_CH-1:0]     res_sat;
  state_t              state;
  logic [2:0]          idx;
  logic [1:0]          dcnt;
  logic                sclk_q;
  logic                frame_edge;
  logic                dp_vld, dp_sat;
  logic [2:0]          dp_idx;
  logic signed [W-1:0] dp_dat;

  assign frame_edge = sclk_q & ~bus.sample_clk;

  ak4619_cal_datapath #(.W(W), .GW(GW), .GAIN_FRAC(GAIN_FRAC)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (state == ISSUE),
    .issue_idx (idx),
    .x         (xs[idx]),
    .coef      (snap[idx]),
    .res_vld   (dp_vld),
    .res_idx   (dp_idx),
    .res_dat   (dp_dat),
    .res_sat   (dp_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) coefs[i] <= COEF_RST;
    end else if (bus.coef_we) begin
      if (bus.coef_sel) coefs[bus.coef_addr].gain <= bus.coef_wdata;
      else              coefs[bus.coef_addr].offset <= CW'($signed(bus.coef_wdata[W-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) res[i] <= '0;
      res_sat <= '0;
    end else if (dp_vld) begin
      res[dp_idx]     <= dp_dat;
      res_sat[dp_idx] <= dp_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sclk_q   <= 1'b0;
      idx      <= '0;
      dcnt     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        xs[i]   <= '0;
        snap[i] <= COEF_RST;
      end
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sat_mask  <= '0;
      bus.cal_out0  <= '0;
      bus.cal_out1  <= '0;
      bus.cal_out2  <= '0;
      bus.cal_out3  <= '0;
      bus.dac_out0  <= '0;
      bus.dac_out1  <= '0;
      bus.dac_out2  <= '0;
      bus.dac_out3  <= '0;
    end else begin
      sclk_q        <= bus.sample_clk;
      bus.out_valid <= 1'b0;
      if (frame_edge && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_edge) begin
            xs[0]       <= bus.adc_raw0;
            xs[1]       <= bus.adc_raw1;
            xs[2]       <= bus.adc_raw2;
            xs[3]       <= bus.adc_raw3;
            xs[N_ADC]   <= bus.dac_in0;
            xs[N_ADC+1] <= bus.dac_in1;
            xs[N_ADC+2] <= bus.dac_in2;
            xs[N_ADC+3] <= bus.dac_in3;
            snap        <= coefs;
            idx         <= '0;
            bus.busy    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 3'd1;
          if (idx == 3'(N_CH - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Three cycles let the last channel clear all pipeline stages.
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd2) state <= PUBLISH;
        end
        PUBLISH: begin
          bus.cal_out0  <= res[0];
          bus.cal_out1  <= res[1];
          bus.cal_out2  <= res[2];
          bus.cal_out3  <= res[3];
          bus.dac_out0  <= res[N_ADC];
          bus.dac_out1  <= res[N_ADC+1];
          bus.dac_out2  <= res[N_ADC+2];
          bus.dac_out3  <= res[N_ADC+3];
          bus.sat_mask  <= res_sat;
          bus.out_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
